conv_feed_tx: RTL and testbench

Host-side transmitter that feeds the convolution device over its `con_valid`/`con_ready` input channel. It walks the schedule the device controller expects and fetches each word from a synchronous source memory:
- per output-channel group, kernel bursts first;
- then, per feature-map row, input preload bursts;
- then one compute burst per output column.

The block sits between the stimulus/host memory and the device top, and is the transmitting end of the device's burst-load protocol.

---
 rtl/conv_feed_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_conv_feed_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feed_tx.sv
// Host-side burst transmitter for the convolution device input channel (kernels, preloads, computes).
// Optional stall counter enabled by defining CONV_FEED_TX_PERF_EN.
module conv_feed_tx #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 20,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int NB_GROUPS          = 11,
  parameter int K_BURSTS           = 6,
  parameter int K_LEN              = 12,
  parameter int I_BURSTS           = 3,
  parameter int I_LEN              = 4,
  parameter int C_LEN              = 4,
  parameter int K_BASE             = 0,
  parameter int I_BASE             = 2**19
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  running,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  con_valid,
  input  logic                  con_ready,
  output logic [DATA_WIDTH-1:0] con_data,
  output logic                  con_last,
  output logic [1:0]            burst_kind,
  output logic [31:0]           stall_cycles
);

  localparam int KB_W = (K_BURSTS > 1) ? $clog2(K_BURSTS) : 1;
  localparam int IB_W = (I_BURSTS > 1) ? $clog2(I_BURSTS) : 1;
  localparam int X_W  = (FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1;
  localparam int Y_W  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int G_W  = (NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1;
  localparam int MAX_KI  = (K_LEN > I_LEN) ? K_LEN : I_LEN;
  localparam int MAX_LEN = (MAX_KI > C_LEN) ? MAX_KI : C_LEN;
  localparam int W_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [KB_W-1:0] KB_LAST = KB_W'(K_BURSTS - 1);
  localparam logic [KB_W-1:0] KB_ONE  = KB_W'(1);
  localparam logic [KB_W-1:0] KB_ZERO = KB_W'(0);
  localparam logic [IB_W-1:0] IB_LAST = IB_W'(I_BURSTS - 1);
  localparam logic [IB_W-1:0] IB_ONE  = IB_W'(1);
  localparam logic [IB_W-1:0] IB_ZERO = IB_W'(0);
  localparam logic [X_W-1:0]  X_LAST  = X_W'(FEATURE_MAP_WIDTH - 1);
  localparam logic [X_W-1:0]  X_ONE   = X_W'(1);
  localparam logic [X_W-1:0]  X_ZERO  = X_W'(0);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [Y_W-1:0]  Y_ONE   = Y_W'(1);
  localparam logic [Y_W-1:0]  Y_ZERO  = Y_W'(0);
  localparam logic [G_W-1:0]  G_LAST  = G_W'(NB_GROUPS - 1);
  localparam logic [G_W-1:0]  G_ONE   = G_W'(1);
  localparam logic [G_W-1:0]  G_ZERO  = G_W'(0);
  localparam logic [W_W-1:0]  W_ZERO  = W_W'(0);
  localparam logic [W_W-1:0]  W_ONE   = W_W'(1);
  localparam logic [W_W-1:0]  K_WLAST = W_W'(K_LEN - 1);
  localparam logic [W_W-1:0]  I_WLAST = W_W'(I_LEN - 1);
  localparam logic [W_W-1:0]  C_WLAST = W_W'(C_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ZERO   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] K_BASE_A = ADDR_WIDTH'(K_BASE);
  localparam logic [ADDR_WIDTH-1:0] I_BASE_A = ADDR_WIDTH'(I_BASE);

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_K    = 2'd1;
  localparam logic [1:0] KIND_P    = 2'd2;
  localparam logic [1:0] KIND_C    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_OFFER  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t                  state_r, state_n;
  logic [1:0]              kind_r, kind_n;
  logic [KB_W-1:0]         kb_r, kb_n;
  logic [IB_W-1:0]         ib_r, ib_n;
  logic [X_W-1:0]          x_r, x_n;
  logic [Y_W-1:0]          y_r, y_n;
  logic [G_W-1:0]          g_r, g_n;
  logic [W_W-1:0]          word_r, word_n;
  logic [ADDR_WIDTH-1:0]   k_ptr_r, k_ptr_n;
  logic [ADDR_WIDTH-1:0]   i_ptr_r, i_ptr_n;
  logic                    running_r, running_n;
  logic                    done_r, done_n;
  logic                    mem_re_r, mem_re_n;
  logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_n;
  logic                    con_valid_r, con_valid_n;
  logic                    con_last_r, con_last_n;

  logic [W_W-1:0]          cur_last_s;
  logic [W_W-1:0]          word_inc_s;
  logic [ADDR_WIDTH-1:0]   cur_ptr_s;
  logic                    take_read_s;
  logic                    offer_read_s;
  logic                    burst_end_s;
  logic                    final_s;

  assign word_inc_s = word_r + W_ONE;

  // Burst length and read pointer of the burst in flight.
  always_comb begin
    cur_last_s = W_ZERO;
    cur_ptr_s  = i_ptr_r;
    case (kind_r)
      KIND_K: begin
        cur_last_s = K_WLAST;
        cur_ptr_s  = k_ptr_r;
      end
      KIND_P:  cur_last_s = I_WLAST;
      KIND_C:  cur_last_s = C_WLAST;
      default: cur_last_s = W_ZERO;
    endcase
  end

  // Next-state, schedule walk and next values of the registered outputs.
  always_comb begin
    state_n      = state_r;
    kind_n       = kind_r;
    kb_n         = kb_r;
    ib_n         = ib_r;
    x_n          = x_r;
    y_n          = y_r;
    g_n          = g_r;
    word_n       = word_r;
    k_ptr_n      = k_ptr_r;
    i_ptr_n      = i_ptr_r;
    running_n    = running_r;
    done_n       = 1'b0;
    mem_re_n     = 1'b0;
    mem_addr_n   = A_ZERO;
    con_valid_n  = 1'b0;
    con_last_n   = 1'b0;
    take_read_s  = 1'b0;
    offer_read_s = 1'b0;
    burst_end_s  = 1'b0;
    final_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n    = ST_FETCH;
          kind_n     = KIND_K;
          kb_n       = KB_ZERO;
          ib_n       = IB_ZERO;
          x_n        = X_ZERO;
          y_n        = Y_ZERO;
          g_n        = G_ZERO;
          word_n     = W_ZERO;
          k_ptr_n    = K_BASE_A;
          i_ptr_n    = I_BASE_A;
          running_n  = 1'b1;
          mem_re_n   = 1'b1;
          mem_addr_n = K_BASE_A;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_n     = ST_OFFER;
        word_n      = W_ZERO;
        take_read_s = 1'b1;
        con_valid_n = 1'b1;
        con_last_n  = (cur_last_s == W_ZERO);
        mem_addr_n  = cur_ptr_s + A_ONE;
      end
      ST_OFFER: begin
        if (con_ready) begin
          if (cur_last_s != W_ZERO) begin
            // word 1 must be read on the handshake cycle itself to stream gap-free
            state_n      = ST_STREAM;
            offer_read_s = 1'b1;
            take_read_s  = 1'b1;
            word_n       = W_ONE;
            con_valid_n  = 1'b1;
            con_last_n   = (cur_last_s == W_ONE);
            mem_re_n     = (cur_last_s != W_ONE);
            mem_addr_n   = cur_ptr_s + A_ONE;
          end else begin
            burst_end_s = 1'b1;
          end
        end else begin
          con_valid_n = 1'b1;
          con_last_n  = con_last_r;
          mem_addr_n  = mem_addr_r;
        end
      end
      ST_STREAM: begin
        if (word_r != cur_last_s) begin
          take_read_s = 1'b1;
          word_n      = word_inc_s;
          con_valid_n = 1'b1;
          con_last_n  = (word_inc_s == cur_last_s);
          mem_re_n    = (word_inc_s != cur_last_s);
          mem_addr_n  = cur_ptr_s + A_ONE;
        end else begin
          burst_end_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_n   = ST_IDLE;
        running_n = 1'b0;
        kind_n    = KIND_NONE;
      end
      default: begin
        state_n   = ST_IDLE;
        running_n = 1'b0;
        kind_n    = KIND_NONE;
      end
    endcase

    if (take_read_s) begin
      if (kind_r == KIND_K) begin
        k_ptr_n = k_ptr_r + A_ONE;
      end else begin
        i_ptr_n = i_ptr_r + A_ONE;
      end
    end else begin
      k_ptr_n = k_ptr_n;
    end

    if (burst_end_s) begin
      case (kind_r)
        KIND_K: begin
          if (kb_r == KB_LAST) begin
            kind_n = KIND_P;
            ib_n   = IB_ZERO;
          end else begin
            kb_n = kb_r + KB_ONE;
          end
        end
        KIND_P: begin
          if (ib_r == IB_LAST) begin
            kind_n = KIND_C;
            x_n    = X_ZERO;
          end else begin
            ib_n = ib_r + IB_ONE;
          end
        end
        KIND_C: begin
          if (x_r == X_LAST) begin
            if (y_r == Y_LAST) begin
              if (g_r == G_LAST) begin
                final_s = 1'b1;
              end else begin
                // new group: kernel pointer carries on, input pointer restarts
                g_n     = g_r + G_ONE;
                y_n     = Y_ZERO;
                kind_n  = KIND_K;
                kb_n    = KB_ZERO;
                i_ptr_n = I_BASE_A;
              end
            end else begin
              y_n    = y_r + Y_ONE;
              kind_n = KIND_P;
              ib_n   = IB_ZERO;
            end
          end else begin
            x_n = x_r + X_ONE;
          end
        end
        default: final_s = 1'b1;
      endcase

      if (final_s) begin
        state_n = ST_DONE;
        done_n  = 1'b1;
        kind_n  = KIND_NONE;
      end else begin
        state_n    = ST_FETCH;
        mem_re_n   = 1'b1;
        mem_addr_n = (kind_n == KIND_K) ? k_ptr_n : i_ptr_n;
      end
    end else begin
      final_s = 1'b0;
    end
  end

  // State, schedule counters and registered outputs.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_r     <= ST_IDLE;
      kind_r      <= KIND_NONE;
      kb_r        <= KB_ZERO;
      ib_r        <= IB_ZERO;
      x_r         <= X_ZERO;
      y_r         <= Y_ZERO;
      g_r         <= G_ZERO;
      word_r      <= W_ZERO;
      k_ptr_r     <= A_ZERO;
      i_ptr_r     <= A_ZERO;
      running_r   <= 1'b0;
      done_r      <= 1'b0;
      mem_re_r    <= 1'b0;
      mem_addr_r  <= A_ZERO;
      con_valid_r <= 1'b0;
      con_last_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      kind_r      <= kind_n;
      kb_r        <= kb_n;
      ib_r        <= ib_n;
      x_r         <= x_n;
      y_r         <= y_n;
      g_r         <= g_n;
      word_r      <= word_n;
      k_ptr_r     <= k_ptr_n;
      i_ptr_r     <= i_ptr_n;
      running_r   <= running_n;
      done_r      <= done_n;
      mem_re_r    <= mem_re_n;
      mem_addr_r  <= mem_addr_n;
      con_valid_r <= con_valid_n;
      con_last_r  <= con_last_n;
    end
  end

  assign running    = running_r;
  assign done       = done_r;
  assign mem_re     = mem_re_r | offer_read_s;
  assign mem_addr   = mem_addr_r;
  assign con_valid  = con_valid_r;
  assign con_last   = con_last_r;
  assign burst_kind = kind_r;
  assign con_data   = con_valid_r ? mem_rdata : {DATA_WIDTH{1'b0}};

`ifdef CONV_FEED_TX_PERF_EN
  logic [31:0] stall_r;

  // Saturating count of OFFER cycles in which the device held off.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stall_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      stall_r <= 32'd0;
    end else if ((state_r == ST_OFFER) && !con_ready && (stall_r != 32'hFFFF_FFFF)) begin
      stall_r <= stall_r + 32'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cycles = stall_r;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_conv_feed_tx.sv
// Directed bench for conv_feed_tx on a small schedule (2x2 map, memory data equals address).
module tb_conv_feed_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic        con_ready, con_ready2;
  logic        running, done, mem_re, con_valid, con_last;
  logic [19:0] mem_addr;
  logic [15:0] mem_rdata = 16'd0;
  logic [15:0] con_data;
  logic [1:0]  burst_kind;
  logic [31:0] stall_cycles;
  logic        running2, done2, mem_re2, con_valid2, con_last2;
  logic [19:0] mem_addr2;
  logic [15:0] mem_rdata2 = 16'd0;
  logic [15:0] con_data2;
  logic [1:0]  burst_kind2;
  logic [31:0] stall_cycles2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int mode, idx, idx2, done_cnt, done2_cnt, done_off, wait_n, acc_cyc;
  bit streaming, offering;
  logic [15:0] hold;

  conv_feed_tx #(
    .DATA_WIDTH(16), .ADDR_WIDTH(20), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .NB_GROUPS(1), .K_BURSTS(2), .K_LEN(3), .I_BURSTS(1), .I_LEN(2), .C_LEN(2),
    .K_BASE(0), .I_BASE(100)
  ) u_dut (
    .clk(clk), .arst_n_in(rst_n), .start(start), .running(running), .done(done),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .con_valid(con_valid), .con_ready(con_ready), .con_data(con_data),
    .con_last(con_last), .burst_kind(burst_kind), .stall_cycles(stall_cycles)
  );

  conv_feed_tx #(
    .DATA_WIDTH(16), .ADDR_WIDTH(20), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .NB_GROUPS(2), .K_BURSTS(2), .K_LEN(3), .I_BURSTS(1), .I_LEN(2), .C_LEN(2),
    .K_BASE(0), .I_BASE(100)
  ) u_dut2 (
    .clk(clk), .arst_n_in(rst_n), .start(start2), .running(running2), .done(done2),
    .mem_re(mem_re2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .con_valid(con_valid2), .con_ready(con_ready2), .con_data(con_data2),
    .con_last(con_last2), .burst_kind(burst_kind2), .stall_cycles(stall_cycles2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_addr[15:0];
    if (mem_re2) mem_rdata2 <= mem_addr2[15:0];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp1_data(input int i);
    if (i < 6) return i;
    return 94 + i;
  endfunction

  function automatic int exp1_last(input int i);
    if (i < 6) return ((i % 3) == 2) ? 1 : 0;
    return (((i - 6) % 2) == 1) ? 1 : 0;
  endfunction

  function automatic int exp1_kind(input int i);
    if (i < 6) return 1;
    return (((i - 6) % 6) < 2) ? 2 : 3;
  endfunction

  function automatic int exp2_data(input int i);
    if (i < 18) return exp1_data(i);
    if (i < 24) return i - 12;
    return i + 76;
  endfunction

  // Sample both DUTs mid-cycle, score transfers and drive con_ready for the next edge.
  task automatic mon();
    bit xfer;
    xfer = 1'b0;
    if (con_valid) begin
      if (streaming) begin
        xfer = 1'b1;
        if (mode == 2) con_ready = ~con_ready;
      end else begin
        if (offering) check_val("offer_hold", 32'(con_data), 32'(hold));
        else begin
          offering = 1'b1;
          hold = con_data;
        end
        if (mode == 1 && wait_n < 5) begin
          con_ready = 1'b0;
          wait_n++;
        end else begin
          con_ready = 1'b1;
          xfer = 1'b1;
          streaming = 1'b1;
          offering = 1'b0;
          wait_n = 0;
        end
      end
    end else begin
      streaming = 1'b0;
      offering = 1'b0;
      con_ready = (mode == 1) ? 1'b0 : 1'b1;
    end
    if (xfer) begin
      check_val("data", 32'(con_data), 32'(exp1_data(idx)));
      check_val("last", 32'(con_last), 32'(exp1_last(idx)));
      check_val("kind", 32'(burst_kind), 32'(exp1_kind(idx)));
      idx++;
    end
    if (done) begin
      done_cnt++;
      done_off = cyc - acc_cyc;
    end
    if (con_valid2) begin
      check_val("d2_data", 32'(con_data2), 32'(exp2_data(idx2)));
      idx2++;
    end
    if (done2) done2_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic begin_phase(input int m);
    mode = m;
    idx = 0;
    done_cnt = 0;
    done_off = -1;
    wait_n = 0;
    streaming = 1'b0;
    offering = 1'b0;
    con_ready = (m == 1) ? 1'b0 : 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit need2);
    int n;
    n = 0;
    while (!(done_cnt > 0 && (!need2 || done2_cnt > 0)) && n < budget) begin
      tick();
      n++;
    end
    check_val("done_seen", 32'(done_cnt), 32'd1);
  endtask

  task automatic check_zero();
    check_val("rst_running", 32'(running), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_mem_re", 32'(mem_re), 32'd0);
    check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_val("rst_valid", 32'(con_valid), 32'd0);
    check_val("rst_data", 32'(con_data), 32'd0);
    check_val("rst_last", 32'(con_last), 32'd0);
    check_val("rst_kind", 32'(burst_kind), 32'd0);
    check_val("rst_stall", stall_cycles, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    con_ready = 1'b1;
    con_ready2 = 1'b1;
    idx2 = 0;
    done2_cnt = 0;
    begin_phase(0);
    repeat (3) @(negedge clk);
    #1;
    check_zero();
    rst_n = 1'b1;
    tick();
    check_val("idle_running", 32'(running), 32'd0);
    check_val("idle_valid", 32'(con_valid), 32'd0);

    // ready always high, both DUTs
    begin_phase(0);
    start2 = 1'b1;
    pulse_start();
    start2 = 1'b0;
    check_val("fetch_mem_re", 32'(mem_re), 32'd1);
    check_val("fetch_addr", 32'(mem_addr), 32'd0);
    check_val("fetch_valid", 32'(con_valid), 32'd0);
    check_val("fetch_running", 32'(running), 32'd1);
    tick();
    check_val("offer_valid", 32'(con_valid), 32'd1);
    wait_done(300, 1'b1);
    repeat (3) tick();
    check_val("p1_words", 32'(idx), 32'd18);
    check_val("p1_done_cnt", 32'(done_cnt), 32'd1);
    check_val("p1_done_cyc", 32'(done_off), 32'd26);
    check_val("p1_running_end", 32'(running), 32'd0);
    check_val("p1_stall", stall_cycles, 32'd0);
    check_val("g2_words", 32'(idx2), 32'd36);
    check_val("g2_done_cnt", 32'(done2_cnt), 32'd1);

    // ready held low 5 cycles at each burst start
    begin_phase(1);
    pulse_start();
    wait_done(300, 1'b0);
    repeat (3) tick();
    check_val("p2_words", 32'(idx), 32'd18);
    check_val("p2_done_cyc", 32'(done_off), 32'd66);
`ifdef CONV_FEED_TX_PERF_EN
    check_val("p2_stall", stall_cycles, 32'd40);
    repeat (5) tick();
    check_val("p2_stall_hold", stall_cycles, 32'd40);
`else
    check_val("p2_stall", stall_cycles, 32'd0);
`endif

    // ready toggling inside bursts
    begin_phase(2);
    pulse_start();
    wait_done(300, 1'b0);
    repeat (3) tick();
    check_val("p3_words", 32'(idx), 32'd18);
    check_val("p3_done_cyc", 32'(done_off), 32'd26);

    // reset in the second kernel burst, then restart
    begin_phase(0);
    pulse_start();
    for (int n = 0; n < 60 && idx < 4; n++) tick();
    check_val("p4_pre_words", 32'(idx), 32'd4);
    rst_n = 1'b0;
    #1;
    check_zero();
    tick();
    rst_n = 1'b1;
    tick();
    begin_phase(0);
    pulse_start();
    wait_done(300, 1'b0);
    repeat (3) tick();
    check_val("p4_words", 32'(idx), 32'd18);
    check_val("p4_done_cyc", 32'(done_off), 32'd26);

    // start while running is ignored
    begin_phase(0);
    pulse_start();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, 1'b0);
    repeat (40) tick();
    check_val("p5_done_cnt", 32'(done_cnt), 32'd1);
    check_val("p5_words", 32'(idx), 32'd18);
    check_val("p5_done_cyc", 32'(done_off), 32'd26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
